clk_period_meter: RTL and testbench

//  Measures the period of a slow, asynchronous square wave (sig_in), such as
//  the 100 Hz tick produced by our clock dividers, against the 50 MHz system

---
 rtl/clk_period_meter.sv | 151 +++++++++++++++
 tb/tb_clk_period_meter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of a slow asynchronous square wave
// (sig_in) in clk cycles, flags lock after LOCK_N consecutive in-tolerance
// periods and pulses lost when no rising edge arrives within TIMEOUT cycles.
// One clock domain (clk); rst_n is asynchronous, active-low.
//
// Output handshake: period_valid is a single-cycle strobe with no ready
// return path. period_count, in_tol and locked are registered and become
// valid in the same cycle that period_valid is high. period_count then holds
// until the next capture. lost is an independent single-cycle strobe.
module clk_period_meter #(
  parameter int CNT_W      = 24,
  parameter int EXP_PERIOD = 500000,
  parameter int TOL        = 500,
  parameter int LOCK_N     = 4,
  parameter int TIMEOUT    = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_count,
  output logic             period_valid,
  output logic             in_tol,
  output logic             locked,
  output logic             lost,
  output logic             state_o
);

  // SEEK waits for the first edge; MEASURE counts between edges.
  typedef enum logic {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int MW = $clog2(LOCK_N + 1);

  // Tolerance bounds and limits as constants of counter width.
  localparam logic [CNT_W-1:0] TOL_LO    = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] TOL_HI    = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_M    = MW'(LOCK_N);
  localparam logic [MW-1:0]    M_ONE     = MW'(1);

  // Synchroniser and edge-detect flops.
  logic s1_q, s2_q, s3_q;
  logic edge_p;

  // Measurement state.
  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [MW-1:0]    match_cnt_q;

  // Registered outputs.
  logic [CNT_W-1:0] period_count_q;
  logic             period_valid_q;
  logic             in_tol_q;
  logic             locked_q;
  logic             lost_q;

  // Next values used when a period is captured.
  logic             in_tol_d;
  logic [MW-1:0]    match_cnt_d;
  logic             locked_d;

  // Two-flop synchroniser followed by a delay flop for rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_p = s2_q & ~s3_q;

  // Tolerance and lock evaluation of the period currently held in count_q.
  always_comb begin
    in_tol_d    = (count_q >= TOL_LO) && (count_q <= TOL_HI);
    match_cnt_d = '0;
    if (in_tol_d) begin
      if (match_cnt_q >= LOCK_M) begin
        match_cnt_d = LOCK_M;
      end else begin
        match_cnt_d = match_cnt_q + M_ONE;
      end
    end
    locked_d = (match_cnt_d == LOCK_M);
  end

  // Period FSM with registered outputs; an edge takes priority over timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SEEK;
      count_q        <= '0;
      match_cnt_q    <= '0;
      period_count_q <= '0;
      period_valid_q <= 1'b0;
      in_tol_q       <= 1'b0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      lost_q         <= 1'b0;
      case (state_q)
        SEEK: begin
          if (edge_p) begin
            count_q <= CNT_ONE;
            state_q <= MEASURE;
          end else begin
            count_q <= '0;
          end
        end
        MEASURE: begin
          if (edge_p) begin
            period_count_q <= count_q;
            period_valid_q <= 1'b1;
            in_tol_q       <= in_tol_d;
            match_cnt_q    <= match_cnt_d;
            locked_q       <= locked_d;
            count_q        <= CNT_ONE;
          end else if (count_q == TIMEOUT_C) begin
            lost_q      <= 1'b1;
            locked_q    <= 1'b0;
            in_tol_q    <= 1'b0;
            match_cnt_q <= '0;
            count_q     <= '0;
            state_q     <= SEEK;
          end else begin
            count_q <= count_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= SEEK;
          count_q <= '0;
        end
      endcase
    end
  end

  assign period_count = period_count_q;
  assign period_valid = period_valid_q;
  assign in_tol       = in_tol_q;
  assign locked       = locked_q;
  assign lost         = lost_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter with EXP_PERIOD=500, TOL=5, LOCK_N=4,
// TIMEOUT=1000. sig_in is driven on the falling clock edge; outputs are
// sampled on the falling edge. A rising edge driven at falling edge N0 is
// reflected on the outputs at falling edge N0+3.
module tb_clk_period_meter;

  localparam int CNT_W = 24;

  logic             clk;
  logic             rst_n;
  logic             sig_in;
  logic [CNT_W-1:0] period_count;
  logic             period_valid;
  logic             in_tol;
  logic             locked;
  logic             lost;
  logic             state_o;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;
  int lost_cnt  = 0;
  int exp_valid_total = 0;

  clk_period_meter #(
    .CNT_W(CNT_W), .EXP_PERIOD(500), .TOL(5), .LOCK_N(4), .TIMEOUT(1000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .period_count(period_count), .period_valid(period_valid),
    .in_tol(in_tol), .locked(locked), .lost(lost), .state_o(state_o)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters
  always @(negedge clk) begin
    if (period_valid === 1'b1) valid_cnt++;
    if (lost === 1'b1) lost_cnt++;
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Drive one rising edge, check the outputs it produces, then complete a
  // period of gap cycles (high for gap/2, low for the rest).
  task automatic rise(input int gap, input logic exp_v, input logic [CNT_W-1:0] exp_cnt,
                      input logic exp_tol, input logic exp_lock, input string name);
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (period_valid !== exp_v) begin
      failures++;
      $display("FAIL %s valid: got %b want %b", name, period_valid, exp_v);
    end
    if (exp_v) begin
      exp_valid_total++;
      checks++;
      if (period_count !== exp_cnt) begin
        failures++;
        $display("FAIL %s period_count: got %0d want %0d", name, period_count, exp_cnt);
      end
      checks++;
      if (in_tol !== exp_tol) begin
        failures++;
        $display("FAIL %s in_tol: got %b want %b", name, in_tol, exp_tol);
      end
      checks++;
      if (locked !== exp_lock) begin
        failures++;
        $display("FAIL %s locked: got %b want %b", name, locked, exp_lock);
      end
    end
    @(negedge clk);
    checks++;
    if (period_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s valid_pulse_width: got %b want 0", name, period_valid);
    end
    repeat (gap / 2 - 4) @(negedge clk);
    sig_in = 1'b0;
    repeat (gap - gap / 2) @(negedge clk);
  endtask

  task automatic check_valid_total(input string name);
    #1;
    checks++;
    if (valid_cnt !== exp_valid_total) begin
      failures++;
      $display("FAIL %s valid_total: got %0d want %0d", name, valid_cnt, exp_valid_total);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({period_count, period_valid, in_tol, locked, lost, state_o} !== '0) begin
      failures++;
      $display("FAIL %s outputs: got cnt=%0d v=%b tol=%b lk=%b lost=%b st=%b want all 0",
               name, period_count, period_valid, in_tol, locked, lost, state_o);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("after_reset");
  endtask

  task automatic test_lock();
    rise(500, 1'b0, 0, 1'b0, 1'b0, "lock_e1");
    for (int i = 2; i <= 6; i++) begin
      rise(500, 1'b1, 500, 1'b1, (i >= 5), $sformatf("lock_e%0d", i));
    end
    check_valid_total("lock");
  endtask

  task automatic test_tolerance();
    rise(506, 1'b1, 500, 1'b1, 1'b1, "tol_e7");
    rise(500, 1'b1, 506, 1'b0, 1'b0, "tol_506");
    rise(500, 1'b1, 500, 1'b1, 1'b0, "tol_relock1");
    rise(500, 1'b1, 500, 1'b1, 1'b0, "tol_relock2");
    rise(495, 1'b1, 500, 1'b1, 1'b0, "tol_relock3");
    rise(505, 1'b1, 495, 1'b1, 1'b1, "tol_495");
    rise(494, 1'b1, 505, 1'b1, 1'b1, "tol_505");
    rise(500, 1'b1, 494, 1'b0, 1'b0, "tol_494");
    check_valid_total("tolerance");
  endtask

  task automatic test_timeout();
    int found;
    int lost_before;
    rise(500, 1'b1, 500, 1'b1, 1'b0, "to_m1");
    rise(500, 1'b1, 500, 1'b1, 1'b0, "to_m2");
    rise(500, 1'b1, 500, 1'b1, 1'b0, "to_m3");
    lost_before = lost_cnt;
    // Last edge before the input stops; locks on this capture.
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    exp_valid_total++;
    checks++;
    if (period_valid !== 1'b1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL to_last_edge: got v=%b lk=%b want v=1 lk=1", period_valid, locked);
    end
    repeat (10) @(negedge clk);
    sig_in = 1'b0;
    found = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (lost === 1'b1) begin
        found = i;
        break;
      end
    end
    checks++;
    if (found != 990) begin
      failures++;
      $display("FAIL to_lost_time: got %0d want 990 cycles after release", found);
    end
    checks++;
    if (locked !== 1'b0 || in_tol !== 1'b0 || state_o !== 1'b0 || period_count !== 500) begin
      failures++;
      $display("FAIL to_state: got lk=%b tol=%b st=%b cnt=%0d want 0 0 0 500",
               locked, in_tol, state_o, period_count);
    end
    @(negedge clk);
    checks++;
    if (lost !== 1'b0) begin
      failures++;
      $display("FAIL to_lost_width: got %b want 0", lost);
    end
    repeat (20) @(negedge clk);
    rise(500, 1'b0, 0, 1'b0, 1'b0, "to_first_after_lost");
    checks++;
    if (lost_cnt - lost_before != 1) begin
      failures++;
      $display("FAIL to_lost_count: got %0d want 1", lost_cnt - lost_before);
    end
    check_valid_total("timeout");
  endtask

  task automatic test_reset_mid();
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    exp_valid_total++;
    checks++;
    if (period_valid !== 1'b1 || period_count !== 500 || locked !== 1'b0) begin
      failures++;
      $display("FAIL rm_pre: got v=%b cnt=%0d lk=%b want 1 500 0", period_valid, period_count, locked);
    end
    repeat (97) @(negedge clk);
    sig_in = 1'b0;
    repeat (150) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rm_async");
    repeat (3) @(negedge clk);
    check_all_zero("rm_held");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all_zero("rm_released");
    rise(500, 1'b0, 0, 1'b0, 1'b0, "rm_first_edge");
    rise(500, 1'b1, 500, 1'b1, 1'b0, "rm_second_edge");
    check_valid_total("reset_mid");
  endtask

  task automatic test_edge_at_timeout();
    int lost_before;
    lost_before = lost_cnt;
    rise(1000, 1'b1, 500, 1'b1, 1'b0, "et_pre");
    rise(1001, 1'b1, 1000, 1'b0, 1'b0, "et_1000");
    checks++;
    if (lost_cnt != lost_before) begin
      failures++;
      $display("FAIL et_no_lost: got %0d lost pulses want 0", lost_cnt - lost_before);
    end
    rise(500, 1'b0, 0, 1'b0, 1'b0, "et_after_1001");
    checks++;
    if (lost_cnt - lost_before != 1) begin
      failures++;
      $display("FAIL et_1001_lost: got %0d lost pulses want 1", lost_cnt - lost_before);
    end
    check_valid_total("edge_at_timeout");
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_lock();
    test_tolerance();
    test_timeout();
    test_reset_mid();
    test_edge_at_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
